exec_unit_pipe: RTL and testbench

Parametrised, two-stage pipelined execute unit that merges the ALU (AND/OR/ADD/SUB/SLT/NOR) and the shifter (SLL/SRL/SRA/ROL) behind one opcode. It uses valid/ready handshakes on both sides. It sits between decode and writeback in the multi-cycle CPU datapath and replaces the separate combinational ALU and shifter. Flags are produced with the result, and back-pressure stalls the pipe without losing or reordering operations.

---
 rtl/exec_pkg.sv | 22 ++
 rtl/exec_unit_pipe_if.sv | 26 ++
 rtl/alu_shift_core.sv | 60 ++++++
 rtl/exec_unit_pipe.sv | 96 +++++++++
 tb/tb_exec_unit_pipe.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/exec_pkg.sv
// Shared opcode encoding for the pipelined execute unit.
// Bit 3 of the opcode selects the shifter group; the rest are ALU ops.
package exec_pkg;

   typedef enum logic [3:0] {
      OP_AND = 4'd0,
      OP_OR  = 4'd1,
      OP_ADD = 4'd2,
      OP_SUB = 4'd3,
      OP_SLT = 4'd4,
      OP_NOR = 4'd5,
      OP_SLL = 4'd8,
      OP_SRL = 4'd9,
      OP_SRA = 4'd10,
      OP_ROL = 4'd11
   } op_e;

   function automatic logic OP_IS_SHIFT(logic [3:0] op);
      return op[3];
   endfunction

endpackage

// File: rtl/exec_unit_pipe_if.sv
// Decode-side request and writeback-side result channels of the execute unit.
// Both channels use valid/ready: a beat moves on a rising edge where valid && ready.
interface exec_unit_pipe_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       in_op;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   logic             out_zero;
   logic             out_overflow;

   modport master (
      output in_valid, in_op, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_result, out_zero, out_overflow
   );

   modport slave (
      input  in_valid, in_op, in_a, in_b, out_ready,
      output in_ready, out_valid, out_result, out_zero, out_overflow
   );
endinterface

// File: rtl/alu_shift_core.sv
// Combinational ALU + shifter behind one opcode; result flags derive from the result.
// Only the low SHW bits of b act as the shift amount.
module alu_shift_core
   import exec_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow
);
   localparam int SHW = $clog2(WIDTH);

   logic [SHW-1:0]     sh;
   logic [WIDTH-1:0]   sum;
   logic [WIDTH-1:0]   diff;
   logic [2*WIDTH-1:0] rot;

   assign sh   = b[SHW-1:0];
   assign sum  = a + b;
   assign diff = a - b;
   // Rotating {a,a} leaves the rotated word in the upper half.
   assign rot  = {a, a} << sh;

   always_comb begin
      result   = '0;
      overflow = 1'b0;
      if (OP_IS_SHIFT(op)) begin
         case (op)
            OP_SLL:  result = a << sh;
            OP_SRL:  result = a >> sh;
            OP_SRA:  result = $signed(a) >>> sh;
            OP_ROL:  result = rot[2*WIDTH-1:WIDTH];
            default: result = '0;
         endcase
      end else begin
         case (op)
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_ADD: begin
               result   = sum;
               overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
               result   = diff;
               overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_NOR:  result = ~(a | b);
            default: result = '0;
         endcase
      end
   end

   assign zero = (result == '0);

endmodule

// File: rtl/exec_unit_pipe.sv
// Two-stage execute pipe: S1 holds the operation, S2 holds result and flags.
// A stage loads when it is empty or the stage after it is loading, so ops never reorder.
module exec_unit_pipe
   import exec_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input logic             clk,
   input logic             rst_n,
   exec_unit_pipe_if.slave io
);
   logic             ready_q, ready_d;
   logic             s1_valid_q, s1_valid_d;
   logic [3:0]       s1_op_q, s1_op_d;
   logic [WIDTH-1:0] s1_a_q, s1_a_d;
   logic [WIDTH-1:0] s1_b_q, s1_b_d;
   logic             s2_valid_q, s2_valid_d;
   logic [WIDTH-1:0] s2_result_q, s2_result_d;
   logic             s2_zero_q, s2_zero_d;
   logic             s2_ovf_q, s2_ovf_d;

   logic             s1_load, s2_load;
   logic [WIDTH-1:0] core_result;
   logic             core_zero, core_ovf;

   alu_shift_core #(.WIDTH(WIDTH)) u_core (
      .op       (s1_op_q),
      .a        (s1_a_q),
      .b        (s1_b_q),
      .result   (core_result),
      .zero     (core_zero),
      .overflow (core_ovf)
   );

   // ready_q keeps the input closed while in reset and opens it one edge after release.
   always_comb begin
      s2_load     = !s2_valid_q || io.out_ready;
      s1_load     = ready_q && (!s1_valid_q || s2_load);
      ready_d     = 1'b1;
      s1_valid_d  = s1_valid_q;
      s1_op_d     = s1_op_q;
      s1_a_d      = s1_a_q;
      s1_b_d      = s1_b_q;
      s2_valid_d  = s2_valid_q;
      s2_result_d = s2_result_q;
      s2_zero_d   = s2_zero_q;
      s2_ovf_d    = s2_ovf_q;
      if (s2_load) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_result_d = core_result;
            s2_zero_d   = core_zero;
            s2_ovf_d    = core_ovf;
         end
      end
      if (s1_load) begin
         s1_valid_d = io.in_valid;
         if (io.in_valid) begin
            s1_op_d = io.in_op;
            s1_a_d  = io.in_a;
            s1_b_d  = io.in_b;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_q     <= 1'b0;
         s1_valid_q  <= 1'b0;
         s1_op_q     <= '0;
         s1_a_q      <= '0;
         s1_b_q      <= '0;
         s2_valid_q  <= 1'b0;
         s2_result_q <= '0;
         s2_zero_q   <= 1'b0;
         s2_ovf_q    <= 1'b0;
      end else begin
         ready_q     <= ready_d;
         s1_valid_q  <= s1_valid_d;
         s1_op_q     <= s1_op_d;
         s1_a_q      <= s1_a_d;
         s1_b_q      <= s1_b_d;
         s2_valid_q  <= s2_valid_d;
         s2_result_q <= s2_result_d;
         s2_zero_q   <= s2_zero_d;
         s2_ovf_q    <= s2_ovf_d;
      end
   end

   assign io.in_ready     = s1_load;
   assign io.out_valid    = s2_valid_q;
   assign io.out_result   = s2_result_q;
   assign io.out_zero     = s2_zero_q;
   assign io.out_overflow = s2_ovf_q;

endmodule

// File: tb/tb_exec_unit_pipe.sv
// Bench for exec_unit_pipe at WIDTH=32 and WIDTH=8: directed vectors, back-pressure,
// mid-flight reset and a randomized scoreboard run against an arithmetic reference model.
module tb_exec_unit_pipe;

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   exec_unit_pipe_if #(.WIDTH(32)) io32 ();
   exec_unit_pipe_if #(.WIDTH(8))  io8 ();

   exec_unit_pipe #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .io(io32));
   exec_unit_pipe #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .io(io8));

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
      logic        z;
      logic        o;
   } vec_t;

   // Reference: {zero, overflow, result} from integer arithmetic on w-bit operands.
   function automatic logic [33:0] model(int w, logic [3:0] op, logic [31:0] a, logic [31:0] b);
      longint mask, half, ua, ub, sa, sb, r, full;
      int     amt;
      logic   ovf;
      mask = (longint'(1) << w) - 1;
      half = longint'(1) << (w - 1);
      ua   = longint'(a) & mask;
      ub   = longint'(b) & mask;
      sa   = (ua >= half) ? ua - (mask + 1) : ua;
      sb   = (ub >= half) ? ub - (mask + 1) : ub;
      amt  = int'(ub % longint'(w));
      ovf  = 1'b0;
      r    = 0;
      case (op)
         4'd0: r = ua & ub;
         4'd1: r = ua | ub;
         4'd2: begin full = sa + sb; r = full; ovf = (full >= half) || (full < -half); end
         4'd3: begin full = sa - sb; r = full; ovf = (full >= half) || (full < -half); end
         4'd4: r = (sa < sb) ? 1 : 0;
         4'd5: r = ~(ua | ub);
         4'd8: r = ua << amt;
         4'd9: r = ua >> amt;
         4'd10: r = sa >>> amt;
         4'd11: r = (ua << amt) | (ua >> (w - amt));
         default: r = 0;
      endcase
      r = r & mask;
      return {(r == 0), ovf, r[31:0]};
   endfunction

   task automatic idle_inputs();
      io32.in_valid = 1'b0; io32.in_op = '0; io32.in_a = '0; io32.in_b = '0; io32.out_ready = 1'b1;
      io8.in_valid  = 1'b0; io8.in_op  = '0; io8.in_a  = '0; io8.in_b  = '0; io8.out_ready  = 1'b1;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      n_cmp++;
      if ({io32.out_valid, io32.in_ready, io32.out_result, io32.out_zero, io32.out_overflow} !== 36'h0) begin
         n_err++;
         $display("FAIL reset_state_w32: got v=%b rdy=%b r=%h z=%b o=%b, want all 0", io32.out_valid,
                  io32.in_ready, io32.out_result, io32.out_zero, io32.out_overflow);
      end
      n_cmp++;
      if ({io8.out_valid, io8.in_ready, io8.out_result, io8.out_zero, io8.out_overflow} !== 12'h0) begin
         n_err++;
         $display("FAIL reset_state_w8: got v=%b rdy=%b r=%h, want all 0", io8.out_valid, io8.in_ready, io8.out_result);
      end
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      n_cmp++;
      if (io32.in_ready !== 1'b1 || io8.in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL ready_after_reset: got %b/%b, want 1/1", io32.in_ready, io8.in_ready);
      end
   endtask

   task automatic test_vectors_w32();
      vec_t tbl[10];
      tbl[0] = '{4'd2,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1};
      tbl[1] = '{4'd3,  32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0};
      tbl[2] = '{4'd3,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1};
      tbl[3] = '{4'd10, 32'h80000000, 32'h00000024, 32'hF8000000, 1'b0, 1'b0};
      tbl[4] = '{4'd9,  32'h80000000, 32'h00000024, 32'h08000000, 1'b0, 1'b0};
      tbl[5] = '{4'd8,  32'h80000000, 32'h00000024, 32'h00000000, 1'b1, 1'b0};
      tbl[6] = '{4'd4,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0};
      tbl[7] = '{4'd11, 32'h80000000, 32'h00000024, 32'h00000008, 1'b0, 1'b0};
      tbl[8] = '{4'd8,  32'h12345678, 32'hFFFFFFE0, 32'h12345678, 1'b0, 1'b0};
      tbl[9] = '{4'd6,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0};
      io32.out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         io32.in_op = tbl[i].op; io32.in_a = tbl[i].a; io32.in_b = tbl[i].b; io32.in_valid = 1'b1;
         #1;
         n_cmp++;
         if (io32.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL vec32_%0d_accept: in_ready=%b, want 1", i, io32.in_ready);
         end
         @(negedge clk);
         io32.in_valid = 1'b0;
         #1;
         n_cmp++;
         if (io32.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL vec32_%0d_latency: out_valid=%b one edge after accept, want 0", i, io32.out_valid);
         end
         @(negedge clk);
         #1;
         n_cmp++;
         if ({io32.out_valid, io32.out_zero, io32.out_overflow, io32.out_result} !== {1'b1, tbl[i].z, tbl[i].o, tbl[i].r}) begin
            n_err++;
            $display("FAIL vec32_%0d_op%0d: got v=%b r=%h z=%b o=%b, want v=1 r=%h z=%b o=%b", i, tbl[i].op,
                     io32.out_valid, io32.out_result, io32.out_zero, io32.out_overflow, tbl[i].r, tbl[i].z, tbl[i].o);
         end
      end
   endtask

   task automatic test_vectors_w8();
      vec_t tbl[3];
      tbl[0] = '{4'd11, 32'h81, 32'h01, 32'h03, 1'b0, 1'b0};
      tbl[1] = '{4'd10, 32'h90, 32'h0A, 32'hE4, 1'b0, 1'b0};
      tbl[2] = '{4'd2,  32'hFF, 32'h01, 32'h00, 1'b1, 1'b0};
      io8.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         io8.in_op = tbl[i].op; io8.in_a = tbl[i].a[7:0]; io8.in_b = tbl[i].b[7:0]; io8.in_valid = 1'b1;
         @(negedge clk);
         io8.in_valid = 1'b0;
         @(negedge clk);
         #1;
         n_cmp++;
         if ({io8.out_valid, io8.out_zero, io8.out_overflow, io8.out_result} !== {1'b1, tbl[i].z, tbl[i].o, tbl[i].r[7:0]}) begin
            n_err++;
            $display("FAIL vec8_%0d_op%0d: got v=%b r=%h z=%b o=%b, want v=1 r=%h z=%b o=%b", i, tbl[i].op,
                     io8.out_valid, io8.out_result, io8.out_zero, io8.out_overflow, tbl[i].r[7:0], tbl[i].z, tbl[i].o);
         end
      end
   endtask

   task automatic test_back_pressure();
      logic [31:0] want[3];
      want[0] = 32'd2; want[1] = 32'd4; want[2] = 32'd6;
      @(negedge clk);
      io32.out_ready = 1'b0;
      io32.in_op = 4'd2; io32.in_a = 32'd1; io32.in_b = 32'd1; io32.in_valid = 1'b1;
      @(negedge clk);
      io32.in_a = 32'd2; io32.in_b = 32'd2;
      #1;
      n_cmp++;
      if (io32.in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL bp_second_accept: in_ready=%b, want 1", io32.in_ready);
      end
      @(negedge clk);
      io32.in_a = 32'd3; io32.in_b = 32'd3;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++;
         if ({io32.in_ready, io32.out_valid, io32.out_result} !== {1'b0, 1'b1, 32'd2}) begin
            n_err++;
            $display("FAIL bp_stall_%0d: got rdy=%b v=%b r=%h, want rdy=0 v=1 r=00000002", i,
                     io32.in_ready, io32.out_valid, io32.out_result);
         end
         @(negedge clk);
      end
      io32.out_ready = 1'b1;
      #1;
      n_cmp++;
      if (io32.in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL bp_accept_on_drain: in_ready=%b, want 1", io32.in_ready);
      end
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++;
         if ({io32.out_valid, io32.out_result} !== {1'b1, want[i]}) begin
            n_err++;
            $display("FAIL bp_drain_%0d: got v=%b r=%h, want v=1 r=%h", i, io32.out_valid, io32.out_result, want[i]);
         end
         @(negedge clk);
         io32.in_valid = 1'b0;
      end
      #1;
      n_cmp++;
      if (io32.out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL bp_empty_after: out_valid=%b, want 0", io32.out_valid);
      end
   endtask

   task automatic test_reset_midflight();
      @(negedge clk);
      io32.out_ready = 1'b0;
      io32.in_op = 4'd1; io32.in_a = 32'h0F0F0F0F; io32.in_b = 32'hF0F0F0F0; io32.in_valid = 1'b1;
      repeat (2) @(negedge clk);
      io32.in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({io32.out_valid, io32.in_ready} !== 2'b00) begin
         n_err++;
         $display("FAIL midreset_async: got v=%b rdy=%b, want 0/0", io32.out_valid, io32.in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      io32.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         n_cmp++;
         if ({io32.out_valid, io32.in_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL midreset_stale_%0d: got v=%b rdy=%b, want v=0 rdy=1", i, io32.out_valid, io32.in_ready);
         end
      end
   endtask

   task automatic test_random();
      logic [33:0] exp32_q[$];
      logic [33:0] exp8_q[$];
      logic [33:0] obs, want, hold32, hold8;
      logic        held32, held8;
      int          pass_cnt;
      int          drained32, drained8, accepted32, accepted8;
      held32 = 1'b0; held8 = 1'b0; hold32 = '0; hold8 = '0;
      drained32 = 0; drained8 = 0; accepted32 = 0; accepted8 = 0;
      pass_cnt = 0;
      for (int cyc = 0; cyc < 640; cyc++) begin
         @(negedge clk);
         if (cyc < 600) begin
            io32.in_valid  = ($urandom_range(0, 3) != 0);
            io32.in_op     = 4'($urandom_range(0, 15));
            io32.in_a      = ($urandom_range(0, 3) == 0) ? {$urandom_range(0, 1) == 1, 31'h0} : $urandom;
            io32.in_b      = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            io32.out_ready = ($urandom_range(0, 2) != 0);
            io8.in_valid   = ($urandom_range(0, 3) != 0);
            io8.in_op      = 4'($urandom_range(0, 15));
            io8.in_a       = 8'($urandom);
            io8.in_b       = 8'($urandom);
            io8.out_ready  = ($urandom_range(0, 2) != 0);
         end else begin
            io32.in_valid = 1'b0; io32.out_ready = 1'b1;
            io8.in_valid  = 1'b0; io8.out_ready  = 1'b1;
         end
         #1;
         obs = {io32.out_zero, io32.out_overflow, io32.out_result};
         if (held32) begin
            n_cmp++;
            if ({io32.out_valid, obs} !== {1'b1, hold32}) begin
               n_err++;
               $display("FAIL rand32_hold cyc%0d: got v=%b %h, want v=1 %h", cyc, io32.out_valid, obs, hold32);
            end
         end
         if (io32.out_valid && io32.out_ready) begin
            n_cmp++;
            want = (exp32_q.size() != 0) ? exp32_q.pop_front() : 34'h3_DEAD_BEEF;
            if (obs !== want) begin
               n_err++;
               $display("FAIL rand32_result cyc%0d: got {z,o,r}=%h, want %h", cyc, obs, want);
            end
            drained32++;
         end
         if (io32.in_valid && io32.in_ready) begin
            exp32_q.push_back(model(32, io32.in_op, io32.in_a, io32.in_b));
            accepted32++;
         end
         held32 = io32.out_valid && !io32.out_ready;
         hold32 = obs;
         obs = {io8.out_zero, io8.out_overflow, 24'h0, io8.out_result};
         if (held8) begin
            n_cmp++;
            if ({io8.out_valid, obs} !== {1'b1, hold8}) begin
               n_err++;
               $display("FAIL rand8_hold cyc%0d: got v=%b %h, want v=1 %h", cyc, io8.out_valid, obs, hold8);
            end
         end
         if (io8.out_valid && io8.out_ready) begin
            n_cmp++;
            want = (exp8_q.size() != 0) ? exp8_q.pop_front() : 34'h3_DEAD_BEEF;
            if (obs !== want) begin
               n_err++;
               $display("FAIL rand8_result cyc%0d: got {z,o,r}=%h, want %h", cyc, obs, want);
            end
            drained8++;
         end
         if (io8.in_valid && io8.in_ready) begin
            exp8_q.push_back(model(8, io8.in_op, {24'h0, io8.in_a}, {24'h0, io8.in_b}));
            accepted8++;
         end
         held8 = io8.out_valid && !io8.out_ready;
         hold8 = obs;
      end
      n_cmp++;
      if (exp32_q.size() != 0 || exp8_q.size() != 0 || drained32 != accepted32 || drained8 != accepted8) begin
         n_err++;
         $display("FAIL rand_leftover: queued %0d/%0d, drained %0d/%0d of accepted %0d/%0d, want none left",
                  exp32_q.size(), exp8_q.size(), drained32, drained8, accepted32, accepted8);
      end
      n_cmp++;
      if (accepted32 < 100 || accepted8 < 100) begin
         n_err++;
         $display("FAIL rand_activity: accepted %0d/%0d, want at least 100 each", accepted32, accepted8);
      end
   endtask

   initial begin
      test_reset();
      test_vectors_w32();
      test_vectors_w8();
      test_back_pressure();
      test_reset_midflight();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
